// File: rtl/loader_pkg.sv
// Shared types and constants for the UART ROM loader and its byte receiver.
package loader_pkg;

  localparam int ADDR_W = 32;
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Frame FSM states
  typedef logic [2:0] ld_state_t;
  localparam ld_state_t ST_IDLE = 3'd0;
  localparam ld_state_t ST_LEN0 = 3'd1;
  localparam ld_state_t ST_LEN1 = 3'd2;
  localparam ld_state_t ST_DATA = 3'd3;
  localparam ld_state_t ST_CSUM = 3'd4;
  localparam ld_state_t ST_DONE = 3'd5;
  localparam ld_state_t ST_ERR  = 3'd6;

  // Byte receiver states
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

  // True while a frame is in progress (timeout and framing errors apply)
  function automatic logic in_frame(input ld_state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling, stop-bit check.
// byte_data is updated in the same cycle byte_valid pulses and holds afterwards.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam logic [31:0] DIV_M1  = 32'(DIV - 1);
  localparam logic [31:0] HALF_M1 = 32'(DIV / 2 - 1);

  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  rx_state_t   rx_state;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  // Synchronise the asynchronous line; rx_prev gives the falling-edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit timing and sampling; idle while the loader is disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else if (!enable) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A glitch shorter than half a bit is not a start bit
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        RX_DATA: begin
          if (cnt == DIV_M1) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          if (cnt == DIV_M1) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rom_loader.sv
// Receives an A5/LEN/DATA/CSUM frame over UART and writes it into the
// instruction ROM, holding the CPU in reset (loading) while the image arrives.
module uart_rom_loader
  import loader_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int MAX_WORDS    = 4096,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              uart_rx,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              loading,
  output logic              done,
  output logic              err
);

  localparam int          DIV     = CLK_FREQ / BAUD;
  localparam logic [31:0] TMO_M1  = 32'(TIMEOUT_BITS * DIV - 1);
  localparam logic [15:0] MAX_N   = 16'(MAX_WORDS);

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;

  ld_state_t   state;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [15:0] idx;
  logic [1:0]  byte_sel;
  logic [31:0] word_buf;
  logic [7:0]  csum;
  logic [31:0] tmo_cnt;
  logic [15:0] n_full;
  logic [15:0] idx_next;

  assign n_full   = {byte_data, len_lo};
  assign idx_next = idx + 16'd1;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .uart_rx   (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // Frame FSM, word assembly, checksum, timeout and the ROM write port
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state     <= ST_IDLE;
      len_lo    <= '0;
      n_words   <= '0;
      idx       <= '0;
      byte_sel  <= '0;
      word_buf  <= '0;
      csum      <= '0;
      tmo_cnt   <= '0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
      loading   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      if (in_frame(state)) tmo_cnt <= byte_valid ? 32'd0 : tmo_cnt + 32'd1;

      case (state)
        ST_LEN0: begin
          if (byte_valid) begin
            len_lo <= byte_data;
            state  <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (byte_valid) begin
            if (n_full == 16'd0 || n_full > MAX_N) begin
              state   <= ST_ERR;
              err     <= 1'b1;
              loading <= 1'b0;
            end else begin
              n_words <= n_full;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (byte_valid) begin
            word_buf[{byte_sel, 3'b000} +: 8] <= byte_data;
            csum     <= csum ^ byte_data;
            byte_sel <= byte_sel + 2'd1;
            if (byte_sel == 2'd3) begin
              rom_we    <= 1'b1;
              rom_wdata <= {byte_data, word_buf[23:0]};
              rom_waddr <= {14'b0, idx, 2'b00};
              idx       <= idx_next;
              if (idx_next == n_words) state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (byte_valid) begin
            loading <= 1'b0;
            if (byte_data == csum) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE, DONE and ERR all listen for a new header
          if (byte_valid && byte_data == HDR_BYTE) begin
            state    <= ST_LEN0;
            loading  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            csum     <= '0;
            idx      <= '0;
            byte_sel <= '0;
            tmo_cnt  <= '0;
          end
        end
      endcase

      // Aborts inside a frame; an arriving byte takes priority over the timeout
      if (in_frame(state) && (frame_err || (tmo_cnt == TMO_M1 && !byte_valid))) begin
        state   <= ST_ERR;
        err     <= 1'b1;
        loading <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Self-checking bench for uart_rom_loader with a short bit period.
module tb_uart_rom_loader;

  localparam int CLK_FREQ     = 1600000;
  localparam int BAUD         = 100000;
  localparam int DIV          = CLK_FREQ / BAUD;
  localparam int MAX_WORDS    = 4096;
  localparam int TIMEOUT_BITS = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        uart_rx;
  logic        rom_we;
  logic [31:0] rom_waddr;
  logic [31:0] rom_wdata;
  logic        loading;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        prev_we  = 1'b0;
  logic [31:0] words[0:7];

  // clock / reset
  always #5 clk = ~clk;

  uart_rom_loader #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .MAX_WORDS   (MAX_WORDS),
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .uart_rx  (uart_rx),
    .rom_we   (rom_we),
    .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata),
    .loading  (loading),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every ROM write must match the head of the expected queue
  always @(negedge clk) begin
    if (rom_we) begin
      check("we_back_to_back", {63'b0, prev_we}, 64'd0);
      if (exp_q.size() == 0) check("spurious_write", {63'b0, rom_we}, 64'd0);
      else check("rom_write", {rom_waddr, rom_wdata}, exp_q.pop_front());
    end
    prev_we = rom_we;
  end

  // driver: one 8N1 byte, LSB first, then a random idle gap
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    uart_rx = stop_bit;
    repeat (DIV) @(posedge clk);
    uart_rx = 1'b1;
    repeat ($urandom_range(DIV + 1, 3 * DIV)) @(posedge clk);
  endtask

  // reference model: expected writes and checksum derived from the word list
  task automatic send_frame(input int n, input logic bad_csum);
    logic [7:0] cs;
    cs = 8'h00;
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({32'(w * 4), words[w]});
      for (int k = 0; k < 4; k++) cs = cs ^ words[w][k*8 +: 8];
    end
    send_byte(8'hA5, 1'b1);
    send_byte(8'(n), 1'b1);
    send_byte(8'(n >> 8), 1'b1);
    check("loading_after_len", {63'b0, loading}, 64'd1);
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++) send_byte(words[w][k*8 +: 8], 1'b1);
    send_byte(bad_csum ? (cs ^ 8'h01) : cs, 1'b1);
  endtask

  task automatic check_outcome(input string name, input logic exp_done, input logic exp_err);
    repeat (4) @(negedge clk);
    check({name, "_done"}, {63'b0, done}, {63'b0, exp_done});
    check({name, "_err"}, {63'b0, err}, {63'b0, exp_err});
    check({name, "_loading"}, {63'b0, loading}, 64'd0);
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rom_we", {63'b0, rom_we}, 64'd0);
    check("rst_loading", {63'b0, loading}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_err", {63'b0, err}, 64'd0);
    check("rst_waddr", {32'b0, rom_waddr}, 64'd0);
    @(posedge clk);
    rst = 1'b0;
    repeat (DIV) @(posedge clk);

    // two-word good frame
    words[0] = 32'h00000013;
    words[1] = 32'h00100093;
    send_frame(2, 1'b0);
    check_outcome("good2", 1'b1, 1'b0);

    // same frame with a corrupted checksum: writes still land
    send_frame(2, 1'b1);
    check_outcome("badcs", 1'b0, 1'b1);

    // zero length
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check_outcome("len0", 1'b0, 1'b1);

    // length one above the ROM depth
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h10, 1'b1);
    check_outcome("len4097", 1'b0, 1'b1);

    // stall mid-word until the inter-byte timeout fires
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (TIMEOUT_BITS * DIV - 6 * DIV) @(negedge clk);
    check("tmo_before_err", {63'b0, err}, 64'd0);
    check("tmo_before_loading", {63'b0, loading}, 64'd1);
    repeat (8 * DIV) @(posedge clk);
    check_outcome("timeout", 1'b0, 1'b1);

    // drop enable while the third data byte is on the wire
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    fork
      send_byte(8'h00, 1'b1);
      begin
        repeat (4 * DIV) @(posedge clk);
        enable = 1'b0;
      end
    join
    check_outcome("en_drop", 1'b0, 1'b0);
    enable = 1'b1;
    repeat (DIV) @(posedge clk);
    words[0] = $urandom;
    send_frame(1, 1'b0);
    check_outcome("en_reload", 1'b1, 1'b0);

    // framing error inside DATA
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    check_outcome("stop_err", 1'b0, 1'b1);

    // garbage in idle (also a framing error there) then a valid frame
    send_byte(8'h55, 1'b1);
    send_byte(8'h3C, 1'b0);
    check("garbage_loading", {63'b0, loading}, 64'd0);
    words[0] = 32'hDEADBEEF;
    send_frame(1, 1'b0);
    check_outcome("after_garbage", 1'b1, 1'b0);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      int   n;
      logic bad;
      n   = $urandom_range(1, 4);
      bad = ($urandom_range(0, 3) == 0);
      for (int w = 0; w < n; w++) words[w] = $urandom;
      send_frame(n, bad);
      check_outcome("rand", !bad, bad);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
